// File: rtl/lif_output_neuron.sv
// rtl/lif_output_neuron.sv - leaky integrate-and-fire output neuron with windowed spike count
module lif_output_neuron #(
    parameter int THRESHOLD  = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACTORY = 2,
    parameter int WINDOW     = 16,
    parameter int POT_WIDTH  = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic                 i_en,
    input  logic [7:0]           i_data,
    output logic                 o_spike,
    output logic [POT_WIDTH-1:0] o_potential,
    output logic [7:0]           o_count,
    output logic                 o_done,
    output logic                 o_busy
);

    localparam int SW = $clog2(WINDOW + 1);
    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [SW-1:0]        LAST_STEP = SW'(WINDOW - 1);
    localparam logic [RW-1:0]        REFR_LOAD = RW'(REFRACTORY);
    localparam logic [POT_WIDTH-1:0] THR       = POT_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, INTEGRATE, REFRACT, DONE} state_t;

    state_t               state, state_nxt;
    logic [POT_WIDTH-1:0] v, v_nxt;
    logic [POT_WIDTH-1:0] leaked, integ;
    logic [POT_WIDTH:0]   sum;
    logic [SW-1:0]        step_cnt, step_nxt;
    logic [RW-1:0]        ref_cnt, ref_nxt;
    logic [7:0]           count, count_nxt;
    logic                 spike_nxt, fire, last_step;

    // One extra bit of headroom so the add can be clamped instead of wrapping.
    always_comb begin
        leaked    = v - (v >> LEAK_SHIFT);
        sum       = {1'b0, leaked} + {{(POT_WIDTH - 7){1'b0}}, i_data};
        integ     = sum[POT_WIDTH] ? {POT_WIDTH{1'b1}} : sum[POT_WIDTH-1:0];
        fire      = (integ >= THR);
        last_step = (step_cnt == LAST_STEP);
    end

    always_comb begin
        state_nxt = state;
        v_nxt     = v;
        step_nxt  = step_cnt;
        ref_nxt   = ref_cnt;
        count_nxt = count;
        spike_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    v_nxt     = '0;
                    count_nxt = '0;
                    step_nxt  = '0;
                    ref_nxt   = '0;
                    state_nxt = INTEGRATE;
                end
            end
            INTEGRATE: begin
                if (i_en) begin
                    step_nxt = step_cnt + 1'b1;
                    if (fire) begin
                        spike_nxt = 1'b1;
                        v_nxt     = '0;
                        count_nxt = (count == 8'hFF) ? count : count + 8'd1;
                        ref_nxt   = REFR_LOAD;
                        state_nxt = (REFRACTORY == 0) ? INTEGRATE : REFRACT;
                    end else begin
                        v_nxt = integ;
                    end
                    // The final step is fully processed before the window closes.
                    if (last_step) state_nxt = DONE;
                end
            end
            REFRACT: begin
                if (i_en) begin
                    step_nxt = step_cnt + 1'b1;
                    v_nxt    = '0;
                    ref_nxt  = ref_cnt - 1'b1;
                    if (ref_cnt == RW'(1)) state_nxt = INTEGRATE;
                    if (last_step) state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            v        <= '0;
            step_cnt <= '0;
            ref_cnt  <= '0;
            count    <= '0;
            o_spike  <= 1'b0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            v        <= v_nxt;
            step_cnt <= step_nxt;
            ref_cnt  <= ref_nxt;
            count    <= count_nxt;
            o_spike  <= spike_nxt;
            o_done   <= (state_nxt == DONE);
            o_busy   <= (state_nxt == INTEGRATE) || (state_nxt == REFRACT);
        end
    end

    assign o_potential = v;
    assign o_count     = count;

endmodule
